// File: rtl/isa_pkg.sv
// Shared definitions for the instruction memory path: widths of the
// instruction memory and the loader state encoding.
package isa_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int INSTR_W     = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } loader_state_t;

endpackage

// File: rtl/instruction_loader.sv
// instruction_loader: receives a program as a byte stream (length byte,
// data bytes, optional checksum byte) and writes it into instruction memory,
// holding the core in reset until a complete, valid load has finished.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing checksum byte, ERR state).
module instruction_loader
    import isa_pkg::*;
#(
    parameter int ADDR_W     = IMEM_ADDR_W,
    parameter int DATA_W     = INSTR_W,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              core_reset_n,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(START_ADDR);
    // A length byte of zero means a full memory image.
    localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LAST_COUNT = (ADDR_W+1)'(1);

    loader_state_t     state_reg, state_next;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W-1:0] index_reg;
    logic              xfer;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_reg;
    logic [DATA_W-1:0] sum_check;
`endif

    assign xfer = in_valid && in_ready;

`ifdef LOADER_CHECKSUM_EN
    // Running sum plus the incoming checksum byte must wrap to zero.
    assign sum_check = DATA_W'(sum_reg + in_data);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next   = state_reg;
        in_ready     = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        core_reset_n = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = LEN;
                end
            end
            LEN: begin
                in_ready = 1'b1;
                if (xfer) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (xfer && (count_reg == LAST_COUNT)) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = CSUM;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                in_ready = 1'b1;
                if (xfer) begin
                    state_next = (sum_check == '0) ? DONE : ERR;
                end
            end
            ERR: begin
                error = 1'b1;
                if (start) begin
                    state_next = LEN;
                end
            end
`endif
            DONE: begin
                done         = 1'b1;
                core_reset_n = 1'b1;
                if (start) begin
                    state_next = LEN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Length/index/sum bookkeeping and the registered memory write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
            index_reg <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_reg   <= '0;
`endif
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
        end else begin
            mem_wr_en <= 1'b0;
            if ((state_reg == LEN) && xfer) begin
                count_reg <= (in_data == '0) ? FULL_COUNT : (ADDR_W+1)'(in_data);
                index_reg <= '0;
`ifdef LOADER_CHECKSUM_EN
                sum_reg   <= '0;
`endif
            end
            if ((state_reg == DATA) && xfer) begin
                mem_wr_en <= 1'b1;
                mem_addr  <= BASE_ADDR + index_reg;
                mem_data  <= in_data;
                index_reg <= index_reg + 1'b1;
                count_reg <= count_reg - LAST_COUNT;
`ifdef LOADER_CHECKSUM_EN
                sum_reg   <= DATA_W'(sum_reg + in_data);
`endif
            end
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Testbench for instruction_loader: scoreboard of expected memory writes,
// pushed as data bytes are driven and popped as write strobes appear.
module tb_instruction_loader;

    localparam int START = 8'hFE;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       mem_wr_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       core_reset_n;
    logic       done;
    logic       error;

    instruction_loader #(
        .ADDR_W     (8),
        .DATA_W     (8),
        .START_ADDR (START)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .core_reset_n (core_reset_n),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] pat[256];
    int         checks = 0;
    int         failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor and per-cycle output invariants.
    always @(negedge clk) begin
        if (mem_wr_en) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", {mem_addr, mem_data}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                $display("write addr=0x%02h data=0x%02h (exp 0x%02h 0x%02h)",
                         mem_addr, mem_data, mon_e.addr, mon_e.data);
                check_eq("wr_addr", mem_addr, mon_e.addr);
                check_eq("wr_data", mem_data, mon_e.data);
            end
        end
        check_eq("done_error_excl", done && error, 0);
        check_eq("crn_tracks_done", core_reset_n, done);
    end

    // Drive one byte; waits (bounded) for in_ready, transfers on the next edge.
    task automatic xfer(input logic [7:0] b, input bit push, input logic [7:0] addr);
        int t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check_eq("ready_timeout", in_ready, 1);
            return;
        end
        if (push) exp_q.push_back({addr, b});
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_to_len_ready", in_ready, 1);
        check_eq("start_done_low", done, 0);
        check_eq("start_err_low", error, 0);
    endtask

    // Full load of pat[0..n-1]; gap inserts an idle cycle after each data byte,
    // mid_start pulses start alongside that data byte index.
    task automatic do_load(input int len, input bit gap, input int mid_start, input bit bad_csum);
        int         n;
        logic [7:0] sum;
        logic [7:0] len_b;
        logic [7:0] cs;
        sum   = 8'h00;
        n     = (len == 0) ? 256 : len;
        len_b = 8'(len);
        pulse_start();
        xfer(len_b, 1'b0, 8'h00);
        for (int i = 0; i < n; i++) begin
            if (i == mid_start) start = 1'b1;
            xfer(pat[i], 1'b1, 8'(START + i));
            sum = sum + pat[i];
            if (gap && i != n - 1) begin
                check_eq("ready_in_gap", in_ready, 1);
                @(negedge clk);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        check_eq("not_done_before_csum", done, 0);
        cs = 8'(0) - sum;
        if (bad_csum) cs = cs - 8'h01;
        xfer(cs, 1'b0, 8'h00);
        check_eq("done_after_load", done, !bad_csum);
        check_eq("error_after_load", error, bad_csum);
        check_eq("crn_after_load", core_reset_n, !bad_csum);
`else
        cs = sum;
        check_eq("done_after_load", done, 1);
        check_eq("error_after_load", error, 0);
        check_eq("crn_after_load", core_reset_n, 1);
`endif
        check_eq("ready_after_load", in_ready, 0);
        in_data  = 8'h5A;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("extra_byte_ignored_done", done, !bad_csum);
        check_eq("queue_drained", exp_q.size(), 0);
        $display("load len=%0d gap=%0d bad=%0d csum=0x%02h done=%0d error=%0d",
                 len, gap, bad_csum, cs, done, error);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_wr_en", mem_wr_en, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_data", mem_data, 0);
        check_eq("rst_crn", core_reset_n, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_error", error, 0);

        // Stray bytes in IDLE are not consumed.
        in_valid = 1'b1;
        in_data  = 8'h33;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("idle_ready", in_ready, 0);

        // L=3, 0x11 0x22 0x33.
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33;
        do_load(3, 1'b0, -1, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        do_load(3, 1'b0, -1, 1'b1);
        do_load(3, 1'b0, -1, 1'b0);
`endif

        // L=4 with in_valid every other cycle; addresses wrap past 0xFF.
        for (int i = 0; i < 4; i++) pat[i] = 8'($urandom_range(0, 255));
        do_load(4, 1'b1, -1, 1'b0);

        // L=0: full 256-byte image, start pulsed mid-stream.
        for (int i = 0; i < 256; i++) pat[i] = 8'($urandom_range(0, 255));
        do_load(0, 1'b0, 100, 1'b0);

        // Reset after 2 of 5 data bytes.
        pulse_start();
        xfer(8'd5, 1'b0, 8'h00);
        xfer(8'hC1, 1'b1, 8'(START + 0));
        xfer(8'hC2, 1'b1, 8'(START + 1));
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hC3;
        @(negedge clk);
        reset = 1'b0;
        check_eq("midrst_in_ready", in_ready, 0);
        check_eq("midrst_wr_en", mem_wr_en, 0);
        check_eq("midrst_addr", mem_addr, 0);
        check_eq("midrst_data", mem_data, 0);
        check_eq("midrst_crn", core_reset_n, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_error", error, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("midrst_not_accepting", in_ready, 0);
        end
        in_valid = 1'b0;
        check_eq("midrst_queue_empty", exp_q.size(), 0);

        // Fresh load after reset: L=2, 0xAA 0x55.
        pat[0] = 8'hAA; pat[1] = 8'h55;
        do_load(2, 1'b0, -1, 1'b0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
